// File: rtl/md_sched_pkg.sv
// md_sched_pkg -- shared md_op encodings, default latencies and FSM state type
// for the multiply/divide scheduler.
// MD_DIV_EN (when defined) makes div/divu valid long operations.

`ifndef MD_SCHED_DEFINES
`define MD_SCHED_DEFINES
`define MD_OP_NONE  3'd0
`define MD_OP_MULT  3'd1
`define MD_OP_MULTU 3'd2
`define MD_OP_DIV   3'd3
`define MD_OP_DIVU  3'd4
`define MD_OP_MTHI  3'd5
`define MD_OP_MTLO  3'd6
`define MD_MULT_CYC 5
`define MD_DIV_CYC  10
`endif

package md_sched_pkg;

    localparam logic [2:0] MD_NONE  = `MD_OP_NONE;
    localparam logic [2:0] MD_MULT  = `MD_OP_MULT;
    localparam logic [2:0] MD_MULTU = `MD_OP_MULTU;
    localparam logic [2:0] MD_DIV   = `MD_OP_DIV;
    localparam logic [2:0] MD_DIVU  = `MD_OP_DIVU;
    localparam logic [2:0] MD_MTHI  = `MD_OP_MTHI;
    localparam logic [2:0] MD_MTLO  = `MD_OP_MTLO;

    // Busy counter width; latencies up to 255 cycles fit.
    localparam int                  MD_CNT_W = 8;
    localparam logic [MD_CNT_W-1:0] CNT_ONE  = 8'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Operations that occupy the unit for several cycles (and stall D).
    function automatic logic is_long_op(input logic [2:0] op);
`ifdef MD_DIV_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    // Operations the unit accepts at all; without the divider, div/divu act as none.
    function automatic logic is_valid_op(input logic [2:0] op);
        return is_long_op(op) || (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_div.sv
// md_div -- divide datapath for the MD scheduler. The quotient/remainder is
// captured into the pending registers at issue; the scheduler's counter supplies
// the DIV_CYC latency before it becomes architectural.
// Only instantiated when MD_DIV_EN is defined.

module md_div (
    input  logic        i_is_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    // Sign-magnitude divide: truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negated stays 0x80000000.
    always_comb begin
        w_a_neg = i_is_signed & i_dividend[31];
        w_b_neg = i_is_signed & i_divisor[31];
        w_a_mag = w_a_neg ? (~i_dividend + 32'd1) : i_dividend;
        w_b_mag = w_b_neg ? (~i_divisor + 32'd1) : i_divisor;
        w_q_mag = '0;
        w_r_mag = '0;
        o_quot  = '0;
        o_rem   = '0;
        if (i_divisor == 32'd0) begin
            o_quot = 32'hFFFF_FFFF;
            o_rem  = i_dividend;
        end else begin
            w_q_mag = w_a_mag / w_b_mag;
            w_r_mag = w_a_mag % w_b_mag;
            o_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
            o_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
        end
    end

endmodule

// File: rtl/md_sched.sv
// md_sched -- multiply/divide scheduler: IDLE/RUN FSM, busy counter, multiplier,
// pending result and architectural HI/LO, plus the D-stage stall request.
// MD_DIV_EN (when defined) adds the md_div datapath and enables div/divu.

module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYC = `MD_MULT_CYC,
    parameter int DIV_CYC  = `MD_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_use_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e           r_state;
    md_state_e           w_state_next;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [31:0]         r_pend_hi;
    logic [31:0]         r_pend_lo;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic                w_issue;
    logic                w_op_long;
    logic                w_accept;
    logic                w_mul_signed;
    logic [63:0]         w_mul_a;
    logic [63:0]         w_mul_b;
    logic [63:0]         w_mul_res;

`ifdef MD_DIV_EN
    logic [31:0]         w_div_quot;
    logic [31:0]         w_div_rem;

    md_div u_md_div (
        .i_is_signed (md_op == MD_DIV),
        .i_dividend  (E_A),
        .i_divisor   (E_B),
        .o_quot      (w_div_quot),
        .o_rem       (w_div_rem)
    );
`endif

    // Issue qualification; a flushed (Req) instruction never starts or stalls.
    always_comb begin
        w_issue   = start & ~Req;
        w_op_long = is_long_op(md_op);
        w_accept  = w_issue & (r_state == ST_IDLE) & is_valid_op(md_op);
        busy      = (r_state == ST_RUN);
        stall     = D_use_md & (busy | (w_issue & w_op_long));
        HI        = r_hi;
        LO        = r_lo;
    end

    // 64-bit product: sign-extending for mult makes the low 64 bits the signed product.
    always_comb begin
        w_mul_signed = (md_op == MD_MULT);
        w_mul_a      = {{32{w_mul_signed & E_A[31]}}, E_A};
        w_mul_b      = {{32{w_mul_signed & E_B[31]}}, E_B};
        w_mul_res    = w_mul_a * w_mul_b;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: RUN on an accepted long op, back to IDLE on the last count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_op_long) w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_ONE)      w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counter, pending result and HI/LO; issues during RUN are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_accept) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    r_pend_hi <= w_mul_res[63:32];
                    r_pend_lo <= w_mul_res[31:0];
                    r_cnt     <= MD_CNT_W'(MULT_CYC);
                end
`ifdef MD_DIV_EN
                MD_DIV, MD_DIVU: begin
                    r_pend_hi <= w_div_rem;
                    r_pend_lo <= w_div_quot;
                    r_cnt     <= MD_CNT_W'(DIV_CYC);
                end
`endif
                MD_MTHI: r_hi <= E_A;
                MD_MTLO: r_lo <= E_A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched -- directed bench for md_sched with hand-computed expectations.
// Expectations for div/divu follow whether MD_DIV_EN is defined for the build.

module tb_md_sched;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        Req      = 1'b0;
    logic        start    = 1'b0;
    logic [2:0]  md_op    = 3'd0;
    logic [31:0] E_A      = '0;
    logic [31:0] E_B      = '0;
    logic        D_use_md = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
    logic        stall_all;
    logic        stall_iss;

    md_sched #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .Req      (Req),
        .start    (start),
        .md_op    (md_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_use_md (D_use_md),
        .busy     (busy),
        .stall    (stall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Present one instruction for one cycle (inputs change on negedge); returns at
    // the negedge after the accepting edge, with stall sampled during the issue cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req, output logic stall_at_issue);
        @(negedge clk);
        start = 1'b1; md_op = op; E_A = a; E_B = b; Req = req;
        #1 stall_at_issue = stall;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; Req = 1'b0;
    endtask

    // Count remaining busy cycles (bounded) and AND stall over them.
    task automatic run_busy(output int n, output logic st_all);
        n = 0;
        st_all = 1'b1;
        while (busy && n < 100) begin
            n++;
            st_all &= stall;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state, and stall during reset depends only on the issue term.
        D_use_md = 1'b1; start = 1'b1; md_op = 3'd1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_stall_mult", 64'(stall), 64'd1);
        md_op = 3'd5;
        #1;
        check("rst_stall_mthi", 64'(stall), 64'd0);
        start = 1'b0; md_op = 3'd0; D_use_md = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // mult -3 * 7
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, stall_iss);
        run_busy(cycles, stall_all);
        check("mult_cycles", 64'(cycles), 64'(MULT_CYC));
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
        check("mult_neg", {HI, LO}, {exp_hi, exp_lo});

        // multu 0xFFFFFFFF * 2
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, stall_iss);
        run_busy(cycles, stall_all);
        exp_hi = 32'd1; exp_lo = 32'hFFFF_FFFE;
        check("multu", {HI, LO}, {exp_hi, exp_lo});

        // mthi / mtlo write at the next edge without busy
        issue(3'd5, 32'h1234, 32'd0, 1'b0, stall_iss);
        exp_hi = 32'h1234;
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi", {HI, LO}, {exp_hi, exp_lo});
        issue(3'd6, 32'hABCD, 32'd0, 1'b0, stall_iss);
        exp_lo = 32'hABCD;
        check("mtlo", {HI, LO}, {exp_hi, exp_lo});

        // divu 100 / 7 with D_use_md held: stall at issue and throughout busy
        D_use_md = 1'b1;
        issue(3'd4, 32'd100, 32'd7, 1'b0, stall_iss);
        run_busy(cycles, stall_all);
        D_use_md = 1'b0;
        check("divu_stall_iss", 64'(stall_iss), DIV_EN ? 64'd1 : 64'd0);
        check("divu_cycles", 64'(cycles), DIV_EN ? 64'(DIV_CYC) : 64'd0);
        check("divu_stall_run", 64'(stall_all), 64'd1);
        if (DIV_EN) begin exp_hi = 32'd2; exp_lo = 32'd14; end
        check("divu", {HI, LO}, {exp_hi, exp_lo});

        // div 5 / 0
        issue(3'd3, 32'd5, 32'd0, 1'b0, stall_iss);
        run_busy(cycles, stall_all);
        check("div0_cycles", 64'(cycles), DIV_EN ? 64'(DIV_CYC) : 64'd0);
        if (DIV_EN) begin exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF; end
        check("div0", {HI, LO}, {exp_hi, exp_lo});

        // div -7 / 2 -> q=-3, r=-1
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, stall_iss);
        run_busy(cycles, stall_all);
        if (DIV_EN) begin exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD; end
        check("div_neg", {HI, LO}, {exp_hi, exp_lo});

        // div 0x80000000 / -1
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, stall_iss);
        run_busy(cycles, stall_all);
        if (DIV_EN) begin exp_hi = 32'd0; exp_lo = 32'h8000_0000; end
        check("div_ovf", {HI, LO}, {exp_hi, exp_lo});

        // mult flushed in its issue cycle: no stall, no busy, no write
        D_use_md = 1'b1;
        issue(3'd1, 32'd9, 32'd9, 1'b1, stall_iss);
        D_use_md = 1'b0;
        check("req_stall", 64'(stall_iss), 64'd0);
        check("req_busy", 64'(busy), 64'd0);
        check("req_hilo", {HI, LO}, {exp_hi, exp_lo});

        // Req pulse at RUN cycle 2 does not abort
        issue(3'd1, 32'd3, 32'd4, 1'b0, stall_iss);
        @(negedge clk);
        Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        run_busy(cycles, stall_all);
        check("req_run_cycles", 64'(cycles + 2), 64'(MULT_CYC));
        exp_hi = 32'd0; exp_lo = 32'd12;
        check("req_run_hilo", {HI, LO}, {exp_hi, exp_lo});

        // Issues during RUN (mthi then mult) are ignored
        issue(3'd1, 32'd2, 32'd3, 1'b0, stall_iss);
        start = 1'b1; md_op = 3'd5; E_A = 32'h99;
        @(negedge clk);
        md_op = 3'd1; E_A = 32'd5; E_B = 32'd5;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        run_busy(cycles, stall_all);
        check("ignore_cycles", 64'(cycles + 2), 64'(MULT_CYC));
        exp_hi = 32'd0; exp_lo = 32'd6;
        check("ignore_hilo", {HI, LO}, {exp_hi, exp_lo});

        // Reset at RUN cycle 3 clears everything at once
        issue(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, stall_iss);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_rel_busy", 64'(busy), 64'd0);
        check("rst_rel_hilo", {HI, LO}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
